fifo_bus_arbiter: RTL and testbench
===================================

FIFO_BUS_ARBITER -- requirements
Module: fifo_bus_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of the FIFO-top bus.
REQ-002 Parameter AW, default 8, address width of the FIFO-top bus.
REQ-003 Parameter MAX_BURST, default 16, maximum beats per grant while the other master requests.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 m0_req, m1_req  input  1 each  master requests bus; held high for the whole burst.
REQ-007 m0_wr, m1_wr  input  1 each  1 = write beat, 0 = read beat.
REQ-008 m0_address, m1_address  input  AW each  FIFO-top address.
REQ-009 m0_din, m1_din  input  DW each  write data.
REQ-010 m0_grant, m1_grant  output  1 each  registered grant; at most one high.
REQ-011 m0_rdata, m1_rdata  output  DW each  registered read data.
REQ-012 m0_rvalid, m1_rvalid  output  1 each  one-cycle read-data strobe.
REQ-013 s_sel, s_wr  output  1 each  FIFO-top select and write.
REQ-014 s_address  output  AW  FIFO-top address.
REQ-015 s_din  output  DW  FIFO-top write data.
REQ-016 s_dout  input  DW  FIFO-top read data, valid in the same cycle as the read beat.

Function
REQ-017 States: IDLE, GNT0, GNT1; mN_grant = 1 exactly in GNTn.
REQ-018 Beat: cycle in GNTn with mN_req = 1; s_sel = 1 only on a beat, else s_sel = 0 and s_wr = 0.
REQ-019 On a beat: s_wr, s_address, s_din = granted master's m*_wr, m*_address, m*_din; otherwise s_address and s_din are 0.
REQ-020 IDLE: one requester -> GNT of that master next cycle; both -> GNT of master named by priority pointer ptr.
REQ-021 Grant latency: request raised in IDLE at cycle t -> grant high at t+1, first beat at t+1.
REQ-022 GNTn -> IDLE when mN_req = 0, with no beat in that cycle.
REQ-023 Beat counter bcnt (width clog2(MAX_BURST)+1) clears on GNT entry and increments per beat.
REQ-024 Beat with bcnt = MAX_BURST-1 and other master requesting -> IDLE; if other not requesting, stay in GNTn and clear bcnt.
REQ-025 Every exit from GNTn passes through IDLE for at least one cycle with s_sel = 0, which is the turnaround gap.
REQ-026 On leaving GNTn, ptr = other master; ptr is unchanged in IDLE.
REQ-027 Read beat by master n at cycle t: mN_rdata = s_dout captured, mN_rvalid = 1 at t+1 for one cycle; mN_rdata holds its value otherwise.
REQ-028 Write beats never raise rvalid.
REQ-029 Requests from the non-granted master are ignored until the arbiter returns to IDLE.

Reset
REQ-030 reset high at a rising edge -> state IDLE, ptr = 0, bcnt = 0, grants 0, rvalid 0, rdata 0, s_sel = s_wr = 0, s_address = s_din = 0, including mid-burst.
REQ-031 The first arbitration after reset release is evaluated in the first cycle with reset low.

Structure
REQ-032 Shared package fifo_arb_pkg holds the state enum, DW/AW defaults and the MAX_BURST default.
REQ-033 Sub-module fifo_arb_rr performs the round-robin pick from (m0_req, m1_req, ptr), purely combinational; all else is inline.

Verification
REQ-034 m0 only, 4 write beats to 8'h21 with din 32'h0000_1111..4444 -> grant at t+1, s_sel high 4 cycles, s_din matches in order, then IDLE.
REQ-035 Both request from IDLE after reset -> m0 granted; MAX_BURST=16 -> 16 beats, 1 gap cycle, m1 granted, ptr = 0 after m1 releases.
REQ-036 m1 read of 8'h20 with s_dout = 32'h1111_1111 -> m1_rdata = 32'h1111_1111, m1_rvalid one cycle later; m0_rvalid stays 0.
REQ-037 m0 alone for 40 beats -> grant uninterrupted, no gap cycles, bcnt wraps at 16.
REQ-038 reset asserted on beat 3 of an m1 burst -> next cycle all outputs 0, state IDLE; m0 and m1 both requesting after release -> m0 granted.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the two-master FIFO-top bus arbiter.
package fifo_arb_pkg;

  localparam int DW_DEFAULT        = 32;
  localparam int AW_DEFAULT        = 8;
  localparam int MAX_BURST_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_arb_rr.sv
// Round-robin pick between two requesters; ptr breaks the tie when both ask.
module fifo_arb_rr
  import fifo_arb_pkg::*;
(
  input  logic m0_req_i,
  input  logic m1_req_i,
  input  logic ptr_i,
  output logic any_o,
  output logic pick_o
);

  assign any_o  = m0_req_i | m1_req_i;
  assign pick_o = (m0_req_i & m1_req_i) ? ptr_i : m1_req_i;

endmodule

// File: rtl/fifo_bus_arbiter.sv
// Two-master arbiter in front of a FIFO-top bus: bounded bursts, one-cycle
// turnaround gap between owners, registered read data return.
module fifo_bus_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int AW        = AW_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_wr,
  input  logic          m1_wr,
  input  logic [AW-1:0] m0_address,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m0_din,
  input  logic [DW-1:0] m1_din,
  output logic          m0_grant,
  output logic          m1_grant,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic          s_sel,
  output logic          s_wr,
  output logic [AW-1:0] s_address,
  output logic [DW-1:0] s_din,
  input  logic [DW-1:0] s_dout
);

  localparam int BCW = $clog2(MAX_BURST) + 1;
  typedef logic [BCW-1:0] bcnt_t;
  localparam bcnt_t BCNT_LAST = bcnt_t'(MAX_BURST - 1);

  arb_state_e    state_q;
  logic          ptr_q;
  bcnt_t         bcnt_q;
  logic          m0_grant_q, m1_grant_q;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  logic beat_m0, beat_m1, beat, other_req;
  logic rr_any, rr_pick;

  fifo_arb_rr u_rr (
    .m0_req_i (m0_req),
    .m1_req_i (m1_req),
    .ptr_i    (ptr_q),
    .any_o    (rr_any),
    .pick_o   (rr_pick)
  );

  assign beat_m0   = (state_q == ST_GNT0) && m0_req;
  assign beat_m1   = (state_q == ST_GNT1) && m1_req;
  assign beat      = beat_m0 | beat_m1;
  assign other_req = (state_q == ST_GNT0) ? m1_req : m0_req;

  // NOTE: every output gets a default before the if-chain so no latch is inferred.
  always_comb begin
    s_sel     = 1'b0;
    s_wr      = 1'b0;
    s_address = '0;
    s_din     = '0;
    if (beat_m0) begin
      s_sel     = 1'b1;
      s_wr      = m0_wr;
      s_address = m0_address;
      s_din     = m0_din;
    end else if (beat_m1) begin
      s_sel     = 1'b1;
      s_wr      = m1_wr;
      s_address = m1_address;
      s_din     = m1_din;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      bcnt_q      <= '0;
      m0_grant_q  <= 1'b0;
      m1_grant_q  <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      // NOTE: read-data holding registers are reset too, so outputs are 0 after reset.
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= beat_m0 & ~m0_wr;
      m1_rvalid_q <= beat_m1 & ~m1_wr;
      if (beat_m0 && !m0_wr) m0_rdata_q <= s_dout;
      if (beat_m1 && !m1_wr) m1_rdata_q <= s_dout;

      case (state_q)
        ST_IDLE: begin
          if (rr_any) begin
            state_q    <= rr_pick ? ST_GNT1 : ST_GNT0;
            m0_grant_q <= ~rr_pick;
            m1_grant_q <= rr_pick;
            bcnt_q     <= '0;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (!beat) begin
            state_q    <= ST_IDLE;
            ptr_q      <= (state_q == ST_GNT0);
            m0_grant_q <= 1'b0;
            m1_grant_q <= 1'b0;
          end else if (bcnt_q == BCNT_LAST) begin
            // Burst limit only yields the bus when the other master is waiting.
            bcnt_q <= '0;
            if (other_req) begin
              state_q    <= ST_IDLE;
              ptr_q      <= (state_q == ST_GNT0);
              m0_grant_q <= 1'b0;
              m1_grant_q <= 1'b0;
            end
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          m0_grant_q <= 1'b0;
          m1_grant_q <= 1'b0;
        end
      endcase
    end
  end

  assign m0_grant  = m0_grant_q;
  assign m1_grant  = m1_grant_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// Self-checking bench: ownership/burst model checked every cycle, plus directed scenarios.
module tb_fifo_bus_arbiter;

  localparam int MAX_BURST = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  wr = 2'b00;
  logic [7:0]  addr [2];
  logic [31:0] din  [2];
  logic [31:0] s_dout = '0;

  logic        m0_grant, m1_grant, m0_rvalid, m1_rvalid, s_sel, s_wr;
  logic [31:0] m0_rdata, m1_rdata, s_din;
  logic [7:0]  s_address;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Model: who owns the bus, beats in the current grant, whose turn on a tie.
  int          owner = -1;
  int          run   = 0;
  int          turn  = 0;
  logic [31:0] rdata_e [2];
  logic        rv_e    [2];

  always #5 clk = ~clk;

  fifo_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m1_req(req[1]),
    .m0_wr(wr[0]), .m1_wr(wr[1]),
    .m0_address(addr[0]), .m1_address(addr[1]),
    .m0_din(din[0]), .m1_din(din[1]),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .s_sel(s_sel), .s_wr(s_wr), .s_address(s_address), .s_din(s_din),
    .s_dout(s_dout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    rv_e[0] = 1'b0;
    rv_e[1] = 1'b0;
    if (reset) begin
      owner = -1; run = 0; turn = 0;
      rdata_e[0] = '0; rdata_e[1] = '0;
    end else if (owner < 0) begin
      if (req == 2'b11)   owner = turn;
      else if (req[0])    owner = 0;
      else if (req[1])    owner = 1;
      run = 0;
    end else if (!req[owner]) begin
      turn  = 1 - owner;
      owner = -1;
    end else begin
      if (!wr[owner]) begin
        rdata_e[owner] = s_dout;
        rv_e[owner]    = 1'b1;
      end
      run++;
      if (run == MAX_BURST) begin
        run = 0;
        if (req[1-owner]) begin
          turn  = 1 - owner;
          owner = -1;
        end
      end
    end
  endtask

  task automatic compare();
    logic        beat;
    logic [7:0]  ea;
    logic [31:0] ed;
    beat = (owner >= 0) && req[owner];
    ea   = beat ? addr[owner] : 8'h00;
    ed   = beat ? din[owner]  : 32'h0;
    check("m0_grant",  m0_grant,  owner == 0);
    check("m1_grant",  m1_grant,  owner == 1);
    check("s_sel",     s_sel,     beat);
    check("s_wr",      s_wr,      beat && wr[owner]);
    check("s_address", s_address, ea);
    check("s_din",     s_din,     ed);
    check("m0_rvalid", m0_rvalid, rv_e[0]);
    check("m1_rvalid", m1_rvalid, rv_e[1]);
    check("m0_rdata",  m0_rdata,  rdata_e[0]);
    check("m1_rdata",  m1_rdata,  rdata_e[1]);
  endtask

  always begin
    @(posedge clk);
    model_step();
  end

  always begin
    @(negedge clk);
    #2;
    if (check_en) compare();
  end

  task automatic step();
    @(negedge clk);
    s_dout = $urandom;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req   = 2'b00;
    step();
    reset = 1'b0;
  endtask

  initial begin
    addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
    rdata_e[0] = '0; rdata_e[1] = '0; rv_e[0] = 1'b0; rv_e[1] = 1'b0;
    step();
    check_en = 1'b1;

    // m0 alone: four write beats to 8'h21
    do_reset();
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h21; din[0] = 32'h0000_1111;
    #3 check("idle_before_grant", {m0_grant, s_sel}, 2'b00);
    check("reset_ptr_rdata", {m0_rdata, m1_rdata}, 64'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      din[0] = 32'h0000_1111 * i;
      #3 check("wr4_grant_sel", {m0_grant, m1_grant, s_sel, s_wr}, 4'b1011);
      check("wr4_din", s_din, 32'h0000_1111 * i);
      check("wr4_addr", s_address, 8'h21);
    end
    step();
    req[0] = 1'b0;
    #3 check("wr4_release", {m0_grant, s_sel}, 2'b10);
    step();
    #3 check("wr4_idle", {m0_grant, m1_grant, s_sel}, 3'b000);

    // both request after reset: m0 bursts MAX_BURST, gap, then m1
    do_reset();
    req = 2'b11; wr = 2'b11;
    #3 check("both_idle", {m0_grant, m1_grant}, 2'b00);
    for (int i = 0; i < MAX_BURST; i++) begin
      step();
      #3 check("both_m0_burst", {m0_grant, m1_grant, s_sel}, 3'b101);
    end
    step();
    #3 check("both_gap", {m0_grant, m1_grant, s_sel}, 3'b000);
    step();
    req[0] = 1'b0;
    #3 check("both_m1_grant", {m0_grant, m1_grant, s_sel}, 3'b011);
    step();
    step();
    step();
    req[1] = 1'b0;
    #3 check("m1_release", {m1_grant, s_sel}, 2'b10);
    step();
    req = 2'b11;
    #3 check("after_m1_idle", {m0_grant, m1_grant}, 2'b00);
    step();
    #3 check("ptr_back_to_m0", {m0_grant, m1_grant}, 2'b10);
    req = 2'b00;
    step();
    step();

    // m1 single read of 8'h20
    do_reset();
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 8'h20;
    step();
    s_dout = 32'h1111_1111;
    #3 check("rd_beat", {m1_grant, s_sel, s_wr}, 3'b110);
    check("rd_addr", s_address, 8'h20);
    step();
    req[1] = 1'b0;
    #3 check("rd_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
    check("rd_rdata", m1_rdata, 32'h1111_1111);
    step();
    #3 check("rd_rvalid_drop", {m1_rvalid, m0_rvalid}, 2'b00);
    check("rd_rdata_hold", m1_rdata, 32'h1111_1111);
    step();

    // m0 alone for 40 beats: burst limit never opens a gap
    do_reset();
    req[0] = 1'b1; wr[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      din[0] = $urandom;
      #3 check("long_m0", {m0_grant, s_sel}, 2'b11);
    end
    req[0] = 1'b0;
    step();
    step();

    // reset on beat 3 of an m1 read burst
    do_reset();
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 8'h44;
    step();
    step();
    step();
    reset = 1'b1;
    #3 check("rst_beat3", {m1_grant, s_sel}, 2'b11);
    check("rst_rvalid_before", m1_rvalid, 1'b1);
    step();
    reset = 1'b0; req = 2'b11;
    #3 check("rst_flags", {m0_grant, m1_grant, m0_rvalid, m1_rvalid, s_sel, s_wr}, 6'b0);
    check("rst_bus", {s_address, s_din}, 40'h0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    step();
    #3 check("rst_rearb_m0", {m0_grant, m1_grant}, 2'b10);

    // randomized traffic with long holds and occasional reset
    for (int i = 0; i < 4000; i++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 2; n++) begin
        if (req[n]) req[n] = ($urandom_range(0, 23) != 0);
        else        req[n] = ($urandom_range(0, 3) == 0);
        wr[n]   = $urandom;
        addr[n] = $urandom;
        din[n]  = $urandom;
      end
    end
    reset = 1'b0; req = 2'b00;
    step();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
